// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word and working-state types, round constants,
// standard IV and the Σ/σ/Ch/Maj helpers built from fixed rotate wiring.
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } work_t;

    localparam logic [255:0] SHA_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam word_t SHA_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ROTR2 ^ ROTR13 ^ ROTR22
    function automatic word_t big_sigma0(input word_t x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    // ROTR6 ^ ROTR11 ^ ROTR25
    function automatic word_t big_sigma1(input word_t x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    // ROTR7 ^ ROTR18 ^ SHR3
    function automatic word_t small_sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // ROTR17 ^ ROTR19 ^ SHR10
    function automatic word_t small_sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // W[t+16] from W[t+14], W[t+9], W[t+1], W[t]
    function automatic word_t sched_word(input word_t w14, input word_t w9,
                                         input word_t w1, input word_t w0);
        return small_sigma1(w14) + w9 + small_sigma0(w1) + w0;
    endfunction

    function automatic work_t add_work(input work_t x, input work_t y);
        work_t r;
        r.a = x.a + y.a;
        r.b = x.b + y.b;
        r.c = x.c + y.c;
        r.d = x.d + y.d;
        r.e = x.e + y.e;
        r.f = x.f + y.f;
        r.g = x.g + y.g;
        r.h = x.h + y.h;
        return r;
    endfunction

endpackage

// File: rtl/sha256_round_engine_if.sv
// Job/digest handshake bundle between the miner datapath and the round engine.
interface sha256_round_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] block_in;
    logic [255:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] digest_out;
    logic         busy;

    modport master (
        output in_valid, block_in, state_in, out_ready,
        input  in_ready, out_valid, digest_out, busy
    );

    modport slave (
        input  in_valid, block_in, state_in, out_ready,
        output in_ready, out_valid, digest_out, busy
    );
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: (a..h, K[t], W[t]) -> next a..h.
module sha256_round
    import sha256_pkg::*;
(
    input  work_t s_i,
    input  word_t k_i,
    input  word_t w_i,
    output work_t s_o
);

    word_t t1_s;
    word_t t2_s;

    // Round temporaries and the standard register shuffle
    always_comb begin
        t1_s   = s_i.h + big_sigma1(s_i.e) + ch(s_i.e, s_i.f, s_i.g) + k_i + w_i;
        t2_s   = big_sigma0(s_i.a) + maj(s_i.a, s_i.b, s_i.c);
        s_o.a  = t1_s + t2_s;
        s_o.b  = s_i.a;
        s_o.c  = s_i.b;
        s_o.d  = s_i.c;
        s_o.e  = s_i.d + t1_s;
        s_o.f  = s_i.e;
        s_o.g  = s_i.f;
        s_o.h  = s_i.g;
    end

endmodule

// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression engine, one round per clock by default.
// Define SHA_UNROLL2_EN to chain two rounds per clock (half the latency).
module sha256_round_engine
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sha256_round_engine_if.slave bus
);

`ifdef SHA_UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int CW = 7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q;
    work_t           work_q;
    work_t           hcopy_q;
    word_t           w_q [0:15];
    logic [CW-1:0]   cnt_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;
    logic [255:0]    digest_q;

    work_t           work_d;
    word_t           w_d [0:15];
    work_t           r0_s;
    word_t           k0_s;
    logic            last_s;

    assign k0_s   = SHA_K[cnt_q[5:0]];
    assign last_s = (cnt_q == CW'(ROUNDS - STEP));

    sha256_round u_round0 (
        .s_i (work_q),
        .k_i (k0_s),
        .w_i (w_q[0]),
        .s_o (r0_s)
    );

`ifdef SHA_UNROLL2_EN
    work_t r1_s;
    word_t k1_s;

    assign k1_s = SHA_K[cnt_q[5:0] + 6'd1];

    sha256_round u_round1 (
        .s_i (r0_s),
        .k_i (k1_s),
        .w_i (w_q[1]),
        .s_o (r1_s)
    );

    // Two rounds per clock; the window advances two words, both new words
    // depend only on the current window so they are computed in parallel
    always_comb begin
        work_d = r1_s;
        for (int i = 0; i < 14; i++) begin
            w_d[i] = w_q[i+2];
        end
        w_d[14] = sched_word(w_q[14], w_q[9],  w_q[1], w_q[0]);
        w_d[15] = sched_word(w_q[15], w_q[10], w_q[2], w_q[1]);
    end
`else
    // One round per clock; head of the window is W[t], tail receives W[t+16]
    always_comb begin
        work_d = r0_s;
        for (int i = 0; i < 15; i++) begin
            w_d[i] = w_q[i+1];
        end
        w_d[15] = sched_word(w_q[14], w_q[9], w_q[1], w_q[0]);
    end
`endif

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            hcopy_q     <= '0;
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= 32'h0000_0000;
            end
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            digest_q    <= 256'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        work_q     <= work_t'(bus.state_in);
                        hcopy_q    <= work_t'(bus.state_in);
                        for (int i = 0; i < 16; i++) begin
                            w_q[i] <= bus.block_in[511 - 32*i -: 32];
                        end
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    work_q <= work_d;
                    w_q    <= w_d;
                    cnt_q  <= cnt_q + CW'(STEP);
                    if (last_s) begin
                        digest_q    <= add_work(hcopy_q, work_d);
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // New job is only accepted from IDLE, i.e. the cycle after release
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.digest_out = digest_q;

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed + randomized bench for sha256_round_engine against a loop-based SHA-256 model.
module tb_sha256_round_engine;
    import sha256_pkg::*;

    localparam int ROUNDS = 64;
`ifdef SHA_UNROLL2_EN
    localparam int LAT = ROUNDS / 2;
`else
    localparam int LAT = ROUNDS;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sha256_round_engine_if bus ();

    sha256_round_engine #(.ROUNDS(ROUNDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_2A = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_2B = {480'h0, 32'h000001c0};
    localparam logic [255:0] DIG_ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] DIG_2 =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference compression: full message schedule array, then ROUNDS rounds
    function automatic logic [255:0] ref_compress(input logic [511:0] blk, input logic [255:0] st);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = st[255 - 32*i -: 32];
        for (int t = 0; t < ROUNDS; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + SHA_K[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = st[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [255:0] rand_state();
        logic [255:0] s;
        for (int i = 0; i < 8; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [511:0] blk, input logic [255:0] st);
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_before_accept", 256'(bus.in_ready), 256'(1));
        bus.block_in = blk;
        bus.state_in = st;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_digest();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("release_out_valid", 256'(bus.out_valid), 256'(0));
        chk("release_in_ready", 256'(bus.in_ready), 256'(1));
    endtask

    task automatic run_job(input string tag, input logic [511:0] blk,
                           input logic [255:0] st, input logic [255:0] exp);
        int lat;
        accept(blk, st);
        chk({tag, "_busy"}, 256'({bus.busy, bus.in_ready}), 256'(2'b10));
        wait_done(lat);
        chk({tag, "_latency"}, 256'(lat), 256'(LAT));
        chk({tag, "_digest"}, bus.digest_out, exp);
        release_digest();
    endtask

    initial begin
        logic [511:0] blk;
        logic [255:0] st;
        logic [255:0] snap;
        logic [255:0] d1;
        logic         stable;
        int           lat;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.block_in  = '0;
        bus.state_in  = '0;
        #12;
        chk("reset_in_ready", 256'(bus.in_ready), 256'(1));
        chk("reset_out_valid", 256'(bus.out_valid), 256'(0));
        chk("reset_busy", 256'(bus.busy), 256'(0));
        chk("reset_digest", bus.digest_out, 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_job("abc", BLK_ABC, SHA_IV, DIG_ABC);
        run_job("empty", BLK_EMPTY, SHA_IV, DIG_EMPTY);
        d1 = ref_compress(BLK_2A, SHA_IV);
        run_job("two_blk1", BLK_2A, SHA_IV, d1);
        run_job("two_blk2", BLK_2B, d1, DIG_2);

        for (int k = 0; k < 4; k++) begin
            blk = rand_block();
            st  = rand_state();
            run_job("random", blk, st, ref_compress(blk, st));
        end

        // Backpressure: out_ready low for 20 cycles with in_valid pulses
        blk = rand_block();
        st  = rand_state();
        accept(blk, st);
        wait_done(lat);
        chk("bp_latency", 256'(lat), 256'(LAT));
        snap   = bus.digest_out;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = i[0];
            bus.block_in = rand_block();
            bus.state_in = rand_state();
            @(posedge clk); #1;
            if (bus.digest_out !== snap || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                stable = 1'b0;
        end
        bus.in_valid = 1'b0;
        chk("bp_stable", 256'(stable), 256'(1));
        chk("bp_digest", bus.digest_out, ref_compress(blk, st));
        release_digest();
        chk("bp_no_queued_job", 256'(bus.busy), 256'(0));

        // Reset mid-job at round 30
        accept(BLK_ABC, SHA_IV);
        repeat ((30 * LAT) / ROUNDS) @(posedge clk);
        #1;
        chk("midrst_busy_before", 256'(bus.busy), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 256'(bus.out_valid), 256'(0));
        chk("midrst_in_ready", 256'(bus.in_ready), 256'(1));
        chk("midrst_busy", 256'(bus.busy), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_job("post_rst_abc", BLK_ABC, SHA_IV, DIG_ABC);

        // Inputs changed after accept must not affect the job
        accept(BLK_ABC, SHA_IV);
        bus.block_in = rand_block();
        bus.state_in = rand_state();
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_done(lat);
        chk("hold_latency", 256'(lat + 3), 256'(LAT));
        chk("hold_digest", bus.digest_out, DIG_ABC);
        release_digest();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sha256_round_engine.md
Name: sha256_round_engine

Overview:
- Iterative SHA-256 compression core for the miner datapath.
- Consumes one 512-bit padded message block plus a 256-bit chaining state (IV or midstate).
- Runs the 64 compression rounds, one per clock, then outputs the feed-forward digest.
- Sits directly downstream of the fixed-rotate shifter blocks: the Σ0/Σ1/σ0/σ1 functions are built from ROTR2/6/7/11/13/17/18/19/22/25 and SHR3/10 wiring.

Parameters:
- ROUNDS, 64, number of compression rounds. Fixed at 64 for SHA-256; exposed only for a reduced-round debug build, legal values 8..64 and even.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  block and state presented
- in_ready  output  1  engine can accept a job
- block_in  input  512  message block; [511:480]=W0 … [31:0]=W15, big-endian words
- state_in  input  256  chaining value; [255:224]=H0=a … [31:0]=H7=h
- out_valid  output  1  digest valid
- out_ready  input  1  consumer accepts digest
- digest_out  output  256  state_in + final working variables, same word order as state_in
- busy  output  1  high while rounds are running

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE, out_valid=0, in_ready=1, busy=0, digest_out=0, round counter=0, working and schedule registers=0.
- A reset asserted mid-job aborts the job. No output is produced for it.
- FSM states: IDLE, ROUND, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready the engine latches:
    - a..h <= state_in
    - H copy <= state_in
    - 16-word W shift register <= block_in
    - cnt <= 0
    - state -> ROUND
  - ROUND: busy=1, in_ready=0. Each edge performs round t=cnt:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]
    - T2 = Σ0(a) + Maj(a,b,c)
    - standard register shuffle
    - all additions are modulo 2^32, carries discarded
  - Schedule: for t<16, W[t] is taken from the shift register head. For t≥16, W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], computed from the 16-word window; the window shifts by one word each round.
  - On the edge completing round ROUNDS-1:
    - digest_out <= H copy + new a..h, word-wise mod 2^32
    - out_valid <= 1
    - state -> DONE
  - DONE: out_valid=1, in_ready=0, digest_out held stable. On out_valid&out_ready: out_valid <= 0, state -> IDLE. A new job cannot be accepted in the same cycle; it is accepted no earlier than the next cycle.
- Latency: out_valid rises exactly ROUNDS clocks (64) after the accept edge.
- Throughput: one block per ROUNDS+2 cycles under continuous handshakes.
- Input stability:
  - block_in and state_in are sampled only at the accept edge; changes afterward are ignored.
  - in_valid asserted in ROUND or DONE is ignored; no queueing.
- out_ready held low leaves the engine in DONE indefinitely with no loss and no corruption.

Optional Feature:
- Macro SHA_UNROLL2_EN.
- Defined: two rounds per clock, using two chained round instances and two schedule words per cycle. The window shifts by two words per cycle. Latency is ROUNDS/2 (32) clocks and cnt steps by 2.
- Not defined: one round per clock as above.
- Digest values are identical in both builds.

Decomposition:
- Shared package sha256_pkg holds:
  - the 64-entry K constant array
  - the standard IV constant (6a09e667 … 5be0cd19)
  - word typedef (32-bit)
  - functions big_sigma0/1, small_sigma0/1, ch, maj, with rotations expressed as fixed concatenations
- One sub-module, sha256_round: purely combinational single-round step taking a..h, K, W and returning the new a..h. It is instanced once, or twice under SHA_UNROLL2_EN.

Test Plan:
- "abc" padded block (61626380 00…00 00000018), state_in=IV → digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with out_valid exactly 64 cycles after accept (32 with macro).
- Empty-message block (80000000, zeros, length 0), IV → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": feed block 1 with IV, then block 2 with digest 1 as state_in → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → digest_out stable, in_ready=0, and in_valid pulses ignored. Release → out_valid falls next edge and in_ready=1.
- Reset mid-job: drop rst_n at round 30 → out_valid=0, in_ready=1, busy=0 immediately. The next "abc" job still yields ba7816bf….
- Input hold check: change block_in and state_in to random values one cycle after accept → digest unchanged from the expected "abc" result.
